// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller port: button encoding, pad addresses and pad modes.
package nes_pkg;

   localparam int unsigned BTN_A      = 0;
   localparam int unsigned BTN_B      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;

   localparam logic [15:0] NES_PAD_ADDR_P1 = 16'h4016;
   localparam logic [15:0] NES_PAD_ADDR_P2 = 16'h4017;

   // First member lands in bit 7, so bit 0 is the A button.
   typedef struct packed {
      logic right;
      logic left;
      logic down;
      logic up;
      logic start;
      logic select;
      logic b;
      logic a;
   } nes_buttons_t;

   typedef enum logic {
      PadShift  = 1'b0,
      PadReload = 1'b1
   } pad_mode_e;

endpackage

// File: rtl/nes_pad_shifter.sv
// One controller pad: button synchroniser plus 4021-style parallel-load / serial-out register.
module nes_pad_shifter
   import nes_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       strobe,
   input  logic       shift_en,
   input  logic [7:0] buttons,
   output logic       bit0
);

   logic [SYNC_STAGES-1:0][7:0] sync_q;
   logic [7:0]                  shreg_q;
   nes_buttons_t                btn_s;
   pad_mode_e                   mode;

   assign btn_s = nes_buttons_t'(sync_q[SYNC_STAGES-1]);
   assign mode  = pad_mode_e'(strobe);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         shreg_q <= 8'hFF;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], buttons};
         unique case (mode)
            PadReload: shreg_q <= btn_s;
            PadShift: begin
               // Ones shift in from the top so an exhausted pad reads back 1.
               if (shift_en) shreg_q <= {1'b1, shreg_q[7:1]};
            end
            default: shreg_q <= shreg_q;
         endcase
      end
   end

   assign bit0 = (mode == PadReload) ? btn_s.a : shreg_q[0];

endmodule

// File: rtl/nes_ctrl_port.sv
// CPU-bus responder for the $4016/$4017 controller registers: decode, strobe latch and read mux.
module nes_ctrl_port
   import nes_pkg::*;
#(
   parameter logic [15:0] P1_ADDR     = NES_PAD_ADDR_P1,
   parameter logic [15:0] P2_ADDR     = NES_PAD_ADDR_P2,
   parameter logic [2:0]  OPEN_BUS    = 3'b010,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        MCLK,
   input  logic        CPU_RESET,
   input  logic        CPU_CE,
   input  logic [15:0] ADDR,
   input  logic        CPU_RW_n,
   input  logic [7:0]  DATA_IN,
   output logic [7:0]  DATA_OUT,
   output logic        DATA_OE,
   input  logic [7:0]  P1_BUTTONS,
   input  logic [7:0]  P2_BUTTONS,
   output logic        STROBE_dbg
);

   logic hit_p1;
   logic hit_p2;
   logic strobe_q;
   logic p1_bit0;
   logic p2_bit0;
   logic rd_bit;
   logic unused_din;

   assign hit_p1     = (ADDR == P1_ADDR);
   assign hit_p2     = (ADDR == P2_ADDR);
   assign unused_din = ^DATA_IN[7:1];

   // Writes to P2_ADDR belong to the APU and are deliberately not decoded here.
   always_ff @(posedge MCLK or posedge CPU_RESET) begin
      if (CPU_RESET) begin
         strobe_q <= 1'b0;
      end else if (CPU_CE && !CPU_RW_n && hit_p1) begin
         strobe_q <= DATA_IN[0];
      end
   end

   nes_pad_shifter #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_pad1 (
      .clk      (MCLK),
      .rst      (CPU_RESET),
      .strobe   (strobe_q),
      .shift_en (CPU_CE && CPU_RW_n && hit_p1),
      .buttons  (P1_BUTTONS),
      .bit0     (p1_bit0)
   );

   nes_pad_shifter #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_pad2 (
      .clk      (MCLK),
      .rst      (CPU_RESET),
      .strobe   (strobe_q),
      .shift_en (CPU_CE && CPU_RW_n && hit_p2),
      .buttons  (P2_BUTTONS),
      .bit0     (p2_bit0)
   );

   always_comb begin
      DATA_OE  = (hit_p1 || hit_p2) && CPU_RW_n && !CPU_RESET;
      rd_bit   = hit_p1 ? p1_bit0 : p2_bit0;
      DATA_OUT = DATA_OE ? {OPEN_BUS, 4'b0000, rd_bit} : 8'h00;
   end

   assign STROBE_dbg = strobe_q;

endmodule

// File: tb/tb_nes_ctrl_port.sv
// Self-checking bench for nes_ctrl_port: vector table through a scoreboard plus multi-cycle sequences.
module tb_nes_ctrl_port;

   logic        MCLK = 1'b0;
   logic        CPU_RESET;
   logic        CPU_CE;
   logic [15:0] ADDR;
   logic        CPU_RW_n;
   logic [7:0]  DATA_IN;
   logic [7:0]  DATA_OUT;
   logic        DATA_OE;
   logic [7:0]  P1_BUTTONS;
   logic [7:0]  P2_BUTTONS;
   logic        STROBE_dbg;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] data;
      logic       oe;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic [7:0]  p1;
      logic [7:0]  p2;
      logic [15:0] addr;
      logic        rw;
      logic [7:0]  din;
      logic [7:0]  exp_data;
      logic        exp_stb;
   } vec_t;
   vec_t vecs[$];

   nes_ctrl_port dut (
      .MCLK       (MCLK),
      .CPU_RESET  (CPU_RESET),
      .CPU_CE     (CPU_CE),
      .ADDR       (ADDR),
      .CPU_RW_n   (CPU_RW_n),
      .DATA_IN    (DATA_IN),
      .DATA_OUT   (DATA_OUT),
      .DATA_OE    (DATA_OE),
      .P1_BUTTONS (P1_BUTTONS),
      .P2_BUTTONS (P2_BUTTONS),
      .STROBE_dbg (STROBE_dbg)
   );

   always #5 MCLK = ~MCLK;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge MCLK);
         CPU_CE   = 1'b0;
         ADDR     = 16'h0000;
         CPU_RW_n = 1'b1;
         DATA_IN  = 8'h00;
      end
   endtask

   // One CPU cycle with CE high for a single MCLK; expectation is queued at drive time.
   task automatic bus(input logic [15:0] a, input logic rw, input logic [7:0] d,
                      input logic [7:0] exp, input string name);
      sb_t e;
      sb_t got;
      @(negedge MCLK);
      ADDR     = a;
      CPU_RW_n = rw;
      DATA_IN  = d;
      CPU_CE   = 1'b1;
      e.oe     = rw && (a == 16'h4016 || a == 16'h4017);
      e.data   = e.oe ? exp : 8'h00;
      sb_q.push_back(e);
      #1;
      got = sb_q.pop_front();
      chk({name, " data"}, DATA_OUT, got.data);
      chk({name, " oe"}, {7'b0, DATA_OE}, {7'b0, got.oe});
      @(posedge MCLK);
      #1;
      CPU_CE = 1'b0;
   endtask

   function automatic vec_t rd(input logic [7:0] p1, input logic [7:0] p2,
                               input logic [15:0] a, input logic [7:0] exp, input logic stb);
      vec_t v;
      v = '{p1: p1, p2: p2, addr: a, rw: 1'b1, din: 8'h00, exp_data: exp, exp_stb: stb};
      return v;
   endfunction

   function automatic vec_t wr(input logic [7:0] p1, input logic [7:0] p2,
                               input logic [15:0] a, input logic [7:0] d, input logic stb);
      vec_t v;
      v = '{p1: p1, p2: p2, addr: a, rw: 1'b0, din: d, exp_data: 8'h00, exp_stb: stb};
      return v;
   endfunction

   initial begin
      logic [7:0] seq1 [10];
      seq1 = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41};

      // Strobe then read a latched 1000_1001 out of pad 1, past exhaustion.
      vecs.push_back(wr(8'h89, 8'h00, 16'h4016, 8'h01, 1'b1));
      vecs.push_back(wr(8'h89, 8'h00, 16'h4016, 8'h00, 1'b0));
      for (int i = 0; i < 10; i++) vecs.push_back(rd(8'h89, 8'h00, 16'h4016, seq1[i], 1'b0));
      // Pad independence, both orientations.
      vecs.push_back(wr(8'hFF, 8'h02, 16'h4016, 8'h01, 1'b1));
      vecs.push_back(wr(8'hFF, 8'h02, 16'h4016, 8'h00, 1'b0));
      vecs.push_back(rd(8'hFF, 8'h02, 16'h4017, 8'h40, 1'b0));
      vecs.push_back(rd(8'hFF, 8'h02, 16'h4017, 8'h41, 1'b0));
      vecs.push_back(rd(8'hFF, 8'h02, 16'h4016, 8'h41, 1'b0));
      vecs.push_back(wr(8'h02, 8'hFF, 16'h4016, 8'h01, 1'b1));
      vecs.push_back(wr(8'h02, 8'hFF, 16'h4016, 8'h00, 1'b0));
      vecs.push_back(rd(8'h02, 8'hFF, 16'h4017, 8'h41, 1'b0));
      vecs.push_back(rd(8'h02, 8'hFF, 16'h4017, 8'h41, 1'b0));
      vecs.push_back(rd(8'h02, 8'hFF, 16'h4016, 8'h40, 1'b0));
      vecs.push_back(rd(8'h02, 8'hFF, 16'h4016, 8'h41, 1'b0));
      // Reads during strobe return live A and never shift.
      vecs.push_back(wr(8'h01, 8'h00, 16'h4016, 8'h01, 1'b1));
      for (int i = 0; i < 3; i++) vecs.push_back(rd(8'h01, 8'h00, 16'h4016, 8'h41, 1'b1));
      vecs.push_back(rd(8'h00, 8'h00, 16'h4016, 8'h40, 1'b1));
      vecs.push_back(rd(8'h00, 8'h01, 16'h4017, 8'h41, 1'b1));
      // Latch zeros; later button changes and a 0->0 strobe must not reload.
      vecs.push_back(wr(8'h00, 8'h00, 16'h4016, 8'h00, 1'b0));
      vecs.push_back(wr(8'hFF, 8'h00, 16'h4016, 8'h00, 1'b0));
      for (int i = 0; i < 8; i++) vecs.push_back(rd(8'hFF, 8'h00, 16'h4016, 8'h40, 1'b0));
      vecs.push_back(wr(8'hFF, 8'h00, 16'h4016, 8'h01, 1'b1));
      vecs.push_back(wr(8'hFF, 8'h00, 16'h4016, 8'h00, 1'b0));
      vecs.push_back(rd(8'hFF, 8'h00, 16'h4016, 8'h41, 1'b0));
      // $4017 write is ignored; unrelated address does not respond.
      vecs.push_back(wr(8'h00, 8'h00, 16'h4017, 8'h01, 1'b0));
      vecs.push_back(rd(8'h00, 8'h00, 16'h4016, 8'h41, 1'b0));
      vecs.push_back(rd(8'h00, 8'h00, 16'h2000, 8'h00, 1'b0));
      // 1->1 strobe keeps reloading.
      vecs.push_back(wr(8'h00, 8'h00, 16'h4016, 8'h01, 1'b1));
      vecs.push_back(wr(8'h00, 8'h00, 16'h4016, 8'h01, 1'b1));
      vecs.push_back(rd(8'h01, 8'h00, 16'h4016, 8'h41, 1'b1));
      vecs.push_back(wr(8'h01, 8'h00, 16'h4016, 8'h00, 1'b0));
      vecs.push_back(rd(8'h00, 8'h00, 16'h4016, 8'h41, 1'b0));

      CPU_RESET  = 1'b1;
      CPU_CE     = 1'b0;
      ADDR       = 16'h4016;
      CPU_RW_n   = 1'b1;
      DATA_IN    = 8'h00;
      P1_BUTTONS = 8'h00;
      P2_BUTTONS = 8'h00;
      repeat (2) @(negedge MCLK);
      #1;
      chk("reset data", DATA_OUT, 8'h00);
      chk("reset oe", {7'b0, DATA_OE}, 8'h00);
      chk("reset strobe", {7'b0, STROBE_dbg}, 8'h00);
      @(negedge MCLK);
      CPU_RESET = 1'b0;
      bus(16'h4016, 1'b1, 8'h00, 8'h41, "first read after reset");

      foreach (vecs[i]) begin
         @(negedge MCLK);
         P1_BUTTONS = vecs[i].p1;
         P2_BUTTONS = vecs[i].p2;
         idle(4);
         bus(vecs[i].addr, vecs[i].rw, vecs[i].din, vecs[i].exp_data, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d strobe", i), {7'b0, STROBE_dbg}, {7'b0, vecs[i].exp_stb});
      end

      // Live A path during strobe tracks the button after the synchroniser depth.
      bus(16'h4016, 1'b0, 8'h01, 8'h00, "lat strobe");
      @(negedge MCLK);
      P1_BUTTONS = 8'h01;
      idle(4);
      @(negedge MCLK);
      ADDR       = 16'h4016;
      CPU_RW_n   = 1'b1;
      P1_BUTTONS = 8'h00;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("sync latency k=%0d", k), DATA_OUT, (k < 2) ? 8'h41 : 8'h40);
         @(negedge MCLK);
      end

      // One CE pulse across a 20-MCLK held read gives exactly one shift.
      P1_BUTTONS = 8'h05;
      idle(4);
      bus(16'h4016, 1'b0, 8'h01, 8'h00, "ce strobe on");
      bus(16'h4016, 1'b0, 8'h00, 8'h00, "ce strobe off");
      bus(16'h4017, 1'b0, 8'h01, 8'h00, "ce apu write");
      @(negedge MCLK);
      ADDR     = 16'h4016;
      CPU_RW_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         CPU_CE = (c == 5);
         #1;
         chk($sformatf("ce hold c=%0d data", c), DATA_OUT, (c <= 5) ? 8'h41 : 8'h40);
         chk($sformatf("ce hold c=%0d oe", c), {7'b0, DATA_OE}, 8'h01);
         chk($sformatf("ce hold c=%0d strobe", c), {7'b0, STROBE_dbg}, 8'h00);
         @(negedge MCLK);
      end
      CPU_CE = 1'b0;
      bus(16'h4016, 1'b1, 8'h00, 8'h40, "ce after hold");
      bus(16'h4016, 1'b1, 8'h00, 8'h41, "ce after hold 2");

      // Mid-sequence asynchronous reset.
      P1_BUTTONS = 8'h00;
      idle(4);
      bus(16'h4016, 1'b0, 8'h01, 8'h00, "rst strobe on");
      bus(16'h4016, 1'b0, 8'h00, 8'h00, "rst strobe off");
      for (int i = 0; i < 3; i++) bus(16'h4016, 1'b1, 8'h00, 8'h40, $sformatf("rst read%0d", i));
      bus(16'h4016, 1'b0, 8'h01, 8'h00, "rst strobe again");
      @(negedge MCLK);
      ADDR     = 16'h4016;
      CPU_RW_n = 1'b1;
      @(posedge MCLK);
      #2;
      CPU_RESET = 1'b1;
      #1;
      chk("mid reset oe", {7'b0, DATA_OE}, 8'h00);
      chk("mid reset data", DATA_OUT, 8'h00);
      chk("mid reset strobe", {7'b0, STROBE_dbg}, 8'h00);
      @(negedge MCLK);
      CPU_RESET = 1'b0;
      bus(16'h4016, 1'b1, 8'h00, 8'h41, "read after mid reset");

      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
